// File: rtl/pll_pkg.sv
// Shared types and default constants for the sampled phase-frequency detector.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } pfd_state_t;

  localparam int PFD_CNT_W      = 8;
  localparam int PFD_LOCK_TOL   = 2;
  localparam int PFD_LOCK_COUNT = 16;

endpackage

// File: rtl/pll_edge_sync.sv
// Two-flop synchroniser plus history flop; rise is a one-cycle pulse, two cycles after the input edge is first sampled.
// No backpressure: the pulse is presented for one cycle only.
module pll_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/sampled_pfd.sv
// Sampled PFD: up/dn from a registered IDLE/UP/DN FSM, acting two clk after an input edge is first sampled.
// No backpressure: phase_err is reported with a one-cycle err_valid pulse and held until the next update.
module sampled_pfd
  import pll_pkg::*;
#(
  parameter int CNT_W      = PFD_CNT_W,
  parameter int LOCK_TOL   = PFD_LOCK_TOL,
  parameter int LOCK_COUNT = PFD_LOCK_COUNT,
  parameter int LOCK_CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked
);

  localparam logic [CNT_W-1:0]      CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      TOL      = CNT_W'(LOCK_TOL);
  localparam logic [LOCK_CNT_W-1:0] LOCK_TGT = LOCK_CNT_W'(LOCK_COUNT);

  pfd_state_t            state;
  logic [CNT_W-1:0]      counter;
  logic [CNT_W-1:0]      counter_inc;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  ref_rise;
  logic                  fb_rise;
  logic                  meas_vld;
  logic [CNT_W-1:0]      meas_mag;
  logic                  slip;

  pll_edge_sync u_ref_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ref_in),
    .rise     (ref_rise)
  );

  pll_edge_sync u_fb_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (fb_in),
    .rise     (fb_rise)
  );

  assign counter_inc = (counter == CNT_MAX) ? counter : counter + CNT_ONE;

  // Measurement and slip decode; the counter never exceeds CNT_MAX so the range stays symmetric.
  always_comb begin
    meas_vld = 1'b0;
    meas_mag = '0;
    slip     = 1'b0;
    case (state)
      IDLE: meas_vld = ref_rise & fb_rise;
      UP: begin
        if (fb_rise) begin
          meas_vld = 1'b1;
          meas_mag = counter;
        end else if (ref_rise) begin
          slip = 1'b1;
        end
      end
      DN: begin
        if (ref_rise) begin
          meas_vld = 1'b1;
          meas_mag = counter;
        end else if (fb_rise) begin
          slip = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      phase_err <= '0;
      err_valid <= 1'b0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      err_valid <= meas_vld;

      case (state)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            phase_err <= '0;
          end else if (ref_rise) begin
            state   <= UP;
            counter <= CNT_ONE;
          end else if (fb_rise) begin
            state   <= DN;
            counter <= CNT_ONE;
          end
        end
        UP: begin
          if (fb_rise) begin
            phase_err <= $signed(counter);
            if (ref_rise) counter <= CNT_ONE;
            else          state   <= IDLE;
          end else begin
            counter <= counter_inc;
          end
        end
        DN: begin
          if (ref_rise) begin
            phase_err <= $signed('0 - counter);
            if (fb_rise) counter <= CNT_ONE;
            else         state   <= IDLE;
          end else begin
            counter <= counter_inc;
          end
        end
        default: state <= IDLE;
      endcase

      if (slip) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (meas_vld) begin
        if (meas_mag <= TOL) begin
          if (lock_cnt != LOCK_TGT) lock_cnt <= lock_cnt + 1'b1;
          if (lock_cnt + 1'b1 == LOCK_TGT) locked <= 1'b1;
        end else begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

  assign up = (state == UP);
  assign dn = (state == DN);

endmodule

// File: tb/tb_sampled_pfd.sv
// Directed and randomized checks of sampled_pfd against an event-level model of edge distance and lock qualification.
module tb_sampled_pfd;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ref_in = 1'b0;
  logic              fb_in = 1'b0;
  logic              up;
  logic              dn;
  logic signed [7:0] phase_err;
  logic              err_valid;
  logic              locked;

  int checks = 0;
  int errors = 0;

  int                up_cnt = 0;
  int                dn_cnt = 0;
  int                both_cnt = 0;
  int                ev_cnt = 0;
  logic signed [7:0] ev_err = '0;
  logic              ev_locked = 1'b0;

  int lock_cnt_m = 0;

  sampled_pfd dut (
    .clk       (clk),
    .rst       (rst),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .up        (up),
    .dn        (dn),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (up) up_cnt++;
    if (dn) dn_cnt++;
    if (up && dn) both_cnt++;
    if (err_valid) begin
      ev_cnt++;
      ev_err    = phase_err;
      ev_locked = locked;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: error is the edge distance, clamped to 127; lock needs 16 consecutive |err|<=2.
  function automatic void model_meas(input int e);
    int a;
    a = (e < 0) ? -e : e;
    if (a <= 2) begin
      if (lock_cnt_m < 16) lock_cnt_m++;
    end else begin
      lock_cnt_m = 0;
    end
  endfunction

  task automatic pair(input string tag, input bit ref_first, input int d);
    int u0, d0, b0, e0, mag, exp_err;
    u0 = up_cnt; d0 = dn_cnt; b0 = both_cnt; e0 = ev_cnt;
    @(negedge clk);
    if (d == 0) begin
      ref_in = 1'b1; fb_in = 1'b1;
    end else begin
      if (ref_first) ref_in = 1'b1;
      else           fb_in  = 1'b1;
      repeat (d) @(negedge clk);
      ref_in = 1'b1; fb_in = 1'b1;
    end
    repeat (6) @(negedge clk);
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (4) @(negedge clk);
    mag     = (d > 127) ? 127 : d;
    exp_err = (d == 0) ? 0 : (ref_first ? mag : -mag);
    model_meas(exp_err);
    chk({tag, "_up"},   up_cnt - u0,   (ref_first && d > 0) ? d : 0);
    chk({tag, "_dn"},   dn_cnt - d0,   (!ref_first && d > 0) ? d : 0);
    chk({tag, "_both"}, both_cnt - b0, 0);
    chk({tag, "_ev"},   ev_cnt - e0,   1);
    chk({tag, "_err"},  ev_err,        exp_err);
    chk({tag, "_lock"}, ev_locked,     (lock_cnt_m >= 16) ? 1 : 0);
    chk({tag, "_hold"}, phase_err,     exp_err);
  endtask

  initial begin
    int u0, e0, d0;
    #1;
    chk("rst_up", up, 0);
    chk("rst_dn", dn, 0);
    chk("rst_err", phase_err, 0);
    chk("rst_vld", err_valid, 0);
    chk("rst_lock", locked, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    pair("ref5", 1'b1, 5);
    pair("fb3", 1'b0, 3);
    pair("simul", 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      pair("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    end

    // Lock acquisition from a known-unlocked start, loss, and re-acquisition.
    pair("unlock", 1'b1, 9);
    for (int i = 0; i < 8; i++) begin
      pair("acq_p2", 1'b1, 2);
      pair("acq_m1", 1'b0, 1);
    end
    chk("acq_locked", locked, 1);
    pair("bad7", 1'b1, 7);
    chk("bad7_locked", locked, 0);
    for (int i = 0; i < 16; i++) begin
      pair("relock", 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    chk("relock_locked", locked, 1);

    // Cycle slip with fb held low, then saturated measurement.
    u0 = up_cnt; e0 = ev_cnt; d0 = dn_cnt;
    @(negedge clk); ref_in = 1'b1;
    repeat (100) @(negedge clk); ref_in = 1'b0;
    repeat (96) @(negedge clk);
    chk("preslip_lock", locked, 1);
    chk("preslip_up", up, 1);
    repeat (4) @(negedge clk); ref_in = 1'b1;
    repeat (6) @(negedge clk);
    lock_cnt_m = 0;
    chk("slip_lock", locked, 0);
    chk("slip_up", up, 1);
    chk("slip_ev", ev_cnt - e0, 0);
    repeat (94) @(negedge clk); ref_in = 1'b0;
    repeat (50) @(negedge clk); fb_in = 1'b1;
    repeat (6) @(negedge clk); fb_in = 1'b0;
    repeat (4) @(negedge clk);
    model_meas(127);
    chk("sat_up", up_cnt - u0, 350);
    chk("sat_dn", dn_cnt - d0, 0);
    chk("sat_ev", ev_cnt - e0, 1);
    chk("sat_err", ev_err, 127);
    chk("sat_lock", locked, (lock_cnt_m >= 16) ? 1 : 0);

    // Asynchronous reset in the middle of an UP interval.
    @(negedge clk); ref_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("midup_up", up, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_up", up, 0);
    chk("arst_dn", dn, 0);
    chk("arst_err", phase_err, 0);
    chk("arst_vld", err_valid, 0);
    chk("arst_lock", locked, 0);
    lock_cnt_m = 0;
    repeat (3) @(negedge clk) ref_in = ~ref_in;
    @(negedge clk); rst = 1'b1;
    u0 = up_cnt; e0 = ev_cnt; d0 = dn_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_up", up_cnt - u0, 0);
    chk("post_rst_dn", dn_cnt - d0, 0);
    chk("post_rst_ev", ev_cnt - e0, 0);
    chk("post_rst_err", phase_err, 0);
    pair("after_rst", 1'b1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sampled_pfd.md
Name: sampled_pfd

Overview:
Digital phase-frequency detector for the PLL loop, directly downstream of the feedback frequency divider.
- Compares ref_in, the reference clock, against fb_in, the divider output, with both sampled on the fast system clock.
- Produces mutually exclusive up/dn pulses for the charge-pump/loop-filter stage.
- Produces a signed phase-error measurement in clk cycles.
- Produces a lock indicator.

Parameters:
CNT_W, 8, width of signed phase-error counter/output; magnitude saturates at 2^(CNT_W-1)-1
LOCK_TOL, 2, max |phase_err| (clk cycles) counted as an in-lock comparison
LOCK_COUNT, 16, consecutive in-lock comparisons required to assert locked
LOCK_CNT_W, 5, width of lock-qualification counter; must hold LOCK_COUNT

Ports:
clk  input  1  system sampling clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (rst==0 resets)
ref_in  input  1  reference clock, asynchronous to clk
fb_in  input  1  divided feedback clock from divider, asynchronous to clk
up  output  1  high while ref edge leads and fb edge is awaited
dn  output  1  high while fb edge leads and ref edge is awaited
phase_err  output  CNT_W  signed two's complement; +: ref leads, -: fb leads
err_valid  output  1  one-cycle pulse when phase_err is updated
locked  output  1  loop-lock indicator

Behaviour:
- Reset (rst low, async): sync flops=0, state=IDLE, counter=0, up=dn=0, phase_err=0, err_valid=0, lock_cnt=0, locked=0. Applies immediately, including mid-UP/DN.
- Input path: each input goes through a 2-flop synchroniser plus a history flop. A rise pulse is high for exactly one cycle when sync2=1 and hist=0.
- Latency: an input rising before edge E0 gives a rise pulse in the cycle after E1. The FSM acts on it at E2, so up/dn changes after E2.
- FSM states: IDLE, UP, DN. up=(state==UP), dn=(state==DN); both are registered and never high together.
- IDLE:
  - ref_rise & fb_rise: stay IDLE; err_valid=1, phase_err=0.
  - ref_rise only: go to UP, counter<=1.
  - fb_rise only: go to DN, counter<=1.
- UP:
  - Each cycle, counter increments, saturating at 2^(CNT_W-1)-1.
  - fb_rise: err_valid=1, phase_err<=+counter, go to IDLE. If ref_rise occurs in the same cycle, re-enter UP with counter<=1 after reporting.
  - ref_rise without fb_rise (cycle slip, frequency error): stay UP, counter keeps running; slip flag clears lock_cnt and locked.
- DN: mirror of UP with ref/fb swapped; phase_err<=-counter.
- Measurement: phase_err equals the distance in clk cycles between the two sampled rise pulses. Magnitude is clamped to 2^(CNT_W-1)-1, so the output range is symmetric.
- Hold/pulse: phase_err holds between updates; err_valid is high one cycle per update.
- Lock qualification on each err_valid:
  - |phase_err|<=LOCK_TOL: lock_cnt increments, saturating at LOCK_COUNT; locked<=1 when the incremented value reaches LOCK_COUNT.
  - Otherwise: lock_cnt<=0, locked<=0 in the same edge as err_valid.
- Slip: any slip clears lock_cnt/locked at that edge.
- Glitches shorter than one clk may be missed; no requirement to detect them.

Decomposition:
- Shared package pll_pkg holds:
  - pfd_state_t enum {IDLE, UP, DN};
  - default constants for CNT_W, LOCK_TOL, LOCK_COUNT.
- One sub-module, pll_edge_sync: 2-flop synchroniser plus rising-edge detect, async active-low reset. It is instantiated twice, for ref_in and fb_in.
- FSM, counter and lock logic live in sampled_pfd.

Test Plan:
- Reset: rst low during activity, ref toggling -> up=dn=0, phase_err=0, err_valid=0, locked=0 immediately; outputs stay 0 until the first new edge after release.
- ref leads: ref_in rises, fb_in rises 5 clk later -> up high exactly 5 cycles, dn stays 0, one err_valid with phase_err=+5 (8'h05).
- fb leads: fb_in rises 3 clk before ref_in -> dn high 3 cycles, err_valid with phase_err=-3 (8'hFD), up stays 0.
- Simultaneous: ref_in and fb_in rise in the same cycle -> err_valid pulse, phase_err=0, up/dn never assert.
- Lock:
  - 16 periods with errors alternating +2/-1 -> locked rises on the 16th err_valid.
  - Then one period with error +7 -> locked falls at that err_valid.
  - Then 16 good periods re-lock.
- Saturation/slip/reset:
  - Toggle ref_in every 200 clk with fb_in held 0 -> up stays high, the second ref edge clears locked.
  - Then release fb -> phase_err=+127 (8'h7F).
  - Assert rst mid-UP -> up drops without waiting for clk.
